// File: rtl/cfu_dpram_engine.sv
// rtl/cfu_dpram_engine.sv - CFU owning a private true-dual-port RAM: read, offset-write, accumulate, clear
// Port A is the only write port; port B reads every cycle so IDLE can launch the read on the accept edge.
module cfu_dpram_engine #(
    parameter int ADDR_W    = 10,
    parameter int WR_OFFSET = 8,
    parameter bit CLEAR_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] OFFSET_A = ADDR_W'(WR_OFFSET);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_A   = {ADDR_W{1'b1}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_ACC_WR = 3'd2;
    localparam logic [2:0] S_CLR    = 3'd3;
    localparam logic [2:0] S_RSP    = 3'd4;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ACCUM = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_rdata_q;

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       opnd_q, opnd_d;
    logic [31:0]       rsp_data_q, rsp_data_d;

    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [31:0]       wdata_a;
    logic [ADDR_W-1:0] addr_b;

    logic              cmd_fire;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              unused_bits;

    assign cmd_op      = cmd_payload_function_id[2:0];
    assign cmd_addr    = cmd_payload_inputs_0[ADDR_W-1:0];
    assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_0[31:ADDR_W]};

    assign cmd_ready             = (state_q == S_IDLE);
    assign cmd_fire              = cmd_valid & cmd_ready;
    assign rsp_valid             = (state_q == S_RSP);
    assign rsp_payload_outputs_0 = rsp_data_q;

    // In IDLE the read address comes straight from the command so data is ready in RD.
    assign addr_b = (state_q == S_IDLE) ? cmd_addr : addr_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        rsp_data_d = rsp_data_q;
        we_a       = 1'b0;
        addr_a     = addr_q;
        wdata_a    = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    opnd_d = cmd_payload_inputs_1;
                    cnt_d  = '0;
                    case (cmd_op)
                        OP_READ, OP_ACCUM: begin
                            state_d = S_RD;
                        end
                        OP_WRITE: begin
                            state_d = S_RD;
                            we_a    = 1'b1;
                            addr_a  = cmd_addr + OFFSET_A;
                            wdata_a = cmd_payload_inputs_1;
                        end
                        OP_CLEAR: begin
                            if (CLEAR_EN) begin
                                state_d = S_CLR;
                            end else begin
                                state_d    = S_RSP;
                                rsp_data_d = '0;
                            end
                        end
                        default: begin
                            state_d    = S_RSP;
                            rsp_data_d = '0;
                        end
                    endcase
                end
            end
            S_RD: begin
                if (op_q == OP_ACCUM) begin
                    rsp_data_d = ram_rdata_q + opnd_q;
                    state_d    = S_ACC_WR;
                end else begin
                    rsp_data_d = ram_rdata_q;
                    state_d    = S_RSP;
                end
            end
            S_ACC_WR: begin
                we_a    = 1'b1;
                addr_a  = addr_q;
                wdata_a = rsp_data_q;
                state_d = S_RSP;
            end
            S_CLR: begin
                we_a    = 1'b1;
                addr_a  = cnt_q;
                wdata_a = '0;
                cnt_d   = cnt_q + ONE_A;
                if (cnt_q == LAST_A) begin
                    state_d    = S_RSP;
                    rsp_data_d = 32'(DEPTH);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Contents are deliberately never reset; nonblocking read gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        ram_rdata_q <= mem[addr_b];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            cnt_q      <= '0;
            opnd_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule
